// File: rtl/psum_rmw_scheduler_if.sv
// Request and BRAM bus bundle for psum_rmw_scheduler.
//   master : cluster array + BRAM side (drives requests and port-A read data)
//   slave  : scheduler side (drives ready, both BRAM ports, acc_done, idle)
// Signals:
//   req_valid/req_ready : per-cluster handshake, at most one ready high
//   req_addr/req_psum   : per-cluster address and LANES x ACC_WIDTH partial sum
//   bram_en_a/bram_addr_a/bram_rdata_a : port-A read (data one cycle later)
//   bram_we_b/bram_addr_b/bram_wdata_b : port-B write
//   acc_done : pulse per committed write; idle : nothing in flight
interface psum_rmw_scheduler_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned LANES      = 6
);
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr;
  logic [NUM_REQ*LANES*ACC_WIDTH-1:0]  req_psum;
  logic                                bram_en_a;
  logic [ADDR_WIDTH-1:0]               bram_addr_a;
  logic [DATA_WIDTH-1:0]               bram_rdata_a;
  logic                                bram_we_b;
  logic [ADDR_WIDTH-1:0]               bram_addr_b;
  logic [DATA_WIDTH-1:0]               bram_wdata_b;
  logic                                acc_done;
  logic                                idle;

  modport master (
    output req_valid, req_addr, req_psum, bram_rdata_a,
    input  req_ready, bram_en_a, bram_addr_a, bram_we_b, bram_addr_b,
           bram_wdata_b, acc_done, idle
  );

  modport slave (
    input  req_valid, req_addr, req_psum, bram_rdata_a,
    output req_ready, bram_en_a, bram_addr_a, bram_we_b, bram_addr_b,
           bram_wdata_b, acc_done, idle
  );
endinterface

// File: rtl/psum_rmw_scheduler.sv
// Round-robin scheduler sharing one dual-port partial-sum BRAM between
// NUM_REQ clusters via a 3-stage read-modify-write pipeline (RD, WAIT, WR).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts everything in flight
//   bus   : psum_rmw_scheduler_if.slave (requests, BRAM ports A/B, status)
// Optional feature macro PSUM_HAZARD_FWD_EN:
//   defined   : same-address hazards never stall; WAIT takes its base from
//               the WR stage or the last committed write (CMT) instead of BRAM
//   undefined : a hazard against RD or WAIT holds all ready low
// req_ready is combinational from req_valid by design of the arbiter.
module psum_rmw_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned LANES      = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  psum_rmw_scheduler_if.slave  bus
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PSUM_W = LANES * ACC_WIDTH;

  // Pipeline and arbiter state
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic                  rd_v_q, rd_v_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [PSUM_W-1:0]     rd_psum_q, rd_psum_d;
  logic                  wait_v_q, wait_v_d;
  logic [ADDR_WIDTH-1:0] wait_addr_q, wait_addr_d;
  logic [PSUM_W-1:0]     wait_psum_q, wait_psum_d;
  logic                  wr_v_q, wr_v_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_wdata_q, wr_wdata_d;
  logic                  idle_q, idle_d;

`ifdef PSUM_HAZARD_FWD_EN
  logic                  cmt_v_q, cmt_v_d;
  logic [ADDR_WIDTH-1:0] cmt_addr_q, cmt_addr_d;
  logic [DATA_WIDTH-1:0] cmt_wdata_q, cmt_wdata_d;
`endif

  logic                  cand_found_c;
  logic [IDX_W-1:0]      cand_idx_c;
  logic [ADDR_WIDTH-1:0] cand_addr_c;
  logic [PSUM_W-1:0]     cand_psum_c;
  logic                  stall_c;
  logic                  accept_c;
  logic [NUM_REQ-1:0]    grant_c;
  logic [DATA_WIDTH-1:0] base_c;
  logic [DATA_WIDTH-1:0] sum_c;
  int unsigned           idx_tmp;

  // Round-robin candidate: first valid index at or after rr, with wrap
  always_comb begin
    cand_found_c = 1'b0;
    cand_idx_c   = '0;
    idx_tmp      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_tmp = 32'(rr_q) + k;
      if (idx_tmp >= NUM_REQ) idx_tmp = idx_tmp - NUM_REQ;
      if (!cand_found_c && bus.req_valid[IDX_W'(idx_tmp)]) begin
        cand_found_c = 1'b1;
        cand_idx_c   = IDX_W'(idx_tmp);
      end
    end
  end

  assign cand_addr_c = bus.req_addr[cand_idx_c*ADDR_WIDTH +: ADDR_WIDTH];
  assign cand_psum_c = bus.req_psum[cand_idx_c*PSUM_W +: PSUM_W];

  // Stall holds the candidate itself; other requesters are never bypassed in
`ifdef PSUM_HAZARD_FWD_EN
  assign stall_c = 1'b0;
`else
  assign stall_c = (rd_v_q   && (rd_addr_q   == cand_addr_c)) ||
                   (wait_v_q && (wait_addr_q == cand_addr_c));
`endif

  assign accept_c = cand_found_c && !stall_c;

  // One-hot ready for the accepted candidate
  always_comb begin
    grant_c = '0;
    if (accept_c) grant_c[cand_idx_c] = 1'b1;
  end

  // WAIT-stage base selection and per-lane wrapping add
  always_comb begin
    base_c = bus.bram_rdata_a;
`ifdef PSUM_HAZARD_FWD_EN
    // WR holds the newest value for the address, so it wins over CMT
    if (wr_v_q && (wr_addr_q == wait_addr_q)) begin
      base_c = wr_wdata_q;
    end else if (cmt_v_q && (cmt_addr_q == wait_addr_q)) begin
      base_c = cmt_wdata_q;
    end
`endif
    sum_c = base_c;
    for (int unsigned k = 0; k < LANES; k++) begin
      sum_c[k*ACC_WIDTH +: ACC_WIDTH] = base_c[k*ACC_WIDTH +: ACC_WIDTH] +
                                        wait_psum_q[k*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // Next-state for arbiter pointer and pipeline stages
  always_comb begin
    rr_d        = rr_q;
    rd_v_d      = accept_c;
    rd_addr_d   = rd_addr_q;
    rd_psum_d   = rd_psum_q;
    wait_v_d    = rd_v_q;
    wait_addr_d = wait_addr_q;
    wait_psum_d = wait_psum_q;
    wr_v_d      = wait_v_q;
    wr_addr_d   = wr_addr_q;
    wr_wdata_d  = wr_wdata_q;

    if (accept_c) begin
      rd_addr_d = cand_addr_c;
      rd_psum_d = cand_psum_c;
      rr_d      = (cand_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : cand_idx_c + 1'b1;
    end
    if (rd_v_q) begin
      wait_addr_d = rd_addr_q;
      wait_psum_d = rd_psum_q;
    end
    if (wait_v_q) begin
      wr_addr_d  = wait_addr_q;
      wr_wdata_d = sum_c;
    end

    idle_d = !(rd_v_d || wait_v_d || wr_v_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      rd_v_q      <= 1'b0;
      rd_addr_q   <= '0;
      rd_psum_q   <= '0;
      wait_v_q    <= 1'b0;
      wait_addr_q <= '0;
      wait_psum_q <= '0;
      wr_v_q      <= 1'b0;
      wr_addr_q   <= '0;
      wr_wdata_q  <= '0;
      idle_q      <= 1'b1;
    end else begin
      rr_q        <= rr_d;
      rd_v_q      <= rd_v_d;
      rd_addr_q   <= rd_addr_d;
      rd_psum_q   <= rd_psum_d;
      wait_v_q    <= wait_v_d;
      wait_addr_q <= wait_addr_d;
      wait_psum_q <= wait_psum_d;
      wr_v_q      <= wr_v_d;
      wr_addr_q   <= wr_addr_d;
      wr_wdata_q  <= wr_wdata_d;
      idle_q      <= idle_d;
    end
  end

`ifdef PSUM_HAZARD_FWD_EN
  // CMT remembers the write the BRAM commits on this edge; a read sampled on
  // the same edge still returns the old word
  always_comb begin
    cmt_v_d     = wr_v_q;
    cmt_addr_d  = cmt_addr_q;
    cmt_wdata_d = cmt_wdata_q;
    if (wr_v_q) begin
      cmt_addr_d  = wr_addr_q;
      cmt_wdata_d = wr_wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmt_v_q     <= 1'b0;
      cmt_addr_q  <= '0;
      cmt_wdata_q <= '0;
    end else begin
      cmt_v_q     <= cmt_v_d;
      cmt_addr_q  <= cmt_addr_d;
      cmt_wdata_q <= cmt_wdata_d;
    end
  end
`endif

  assign bus.req_ready    = grant_c;
  assign bus.bram_en_a    = rd_v_q;
  assign bus.bram_addr_a  = rd_addr_q;
  assign bus.bram_we_b    = wr_v_q;
  assign bus.bram_addr_b  = wr_addr_q;
  assign bus.bram_wdata_b = wr_wdata_q;
  assign bus.acc_done     = wr_v_q;
  assign bus.idle         = idle_q;

endmodule

// File: tb/tb_psum_rmw_scheduler.sv
// Self-checking bench for psum_rmw_scheduler: BRAM model, sequential
// reference memory feeding a write scoreboard, table vectors and corner cases.
module tb_psum_rmw_scheduler;

  localparam int unsigned NR = 4;

  logic clk;
  logic rst_n;

  psum_rmw_scheduler_if #(.NUM_REQ(NR), .ADDR_WIDTH(32), .DATA_WIDTH(128),
                          .ACC_WIDTH(16), .LANES(6)) bus ();

  psum_rmw_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(32), .DATA_WIDTH(128),
                       .ACC_WIDTH(16), .LANES(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [NR-1:0] vld;
  logic [31:0]   addr_a [NR];
  logic [95:0]   psum_a [NR];

  always_comb begin
    bus.req_valid = vld;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[i*32 +: 32] = addr_a[i];
      bus.req_psum[i*96 +: 96] = psum_a[i];
    end
  end

  // BRAM model: read-first on a same-edge read/write collision
  logic [127:0] mem     [logic [31:0]];
  logic [127:0] ref_mem [logic [31:0]];

  initial bus.bram_rdata_a = '0;
  always @(posedge clk) begin
    if (bus.bram_en_a)
      bus.bram_rdata_a <= mem.exists(bus.bram_addr_a) ? mem[bus.bram_addr_a] : 128'h0;
    if (bus.bram_we_b) mem[bus.bram_addr_b] = bus.bram_wdata_b;
  end

  function automatic logic [127:0] rref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 128'h0;
  endfunction

  function automatic logic [127:0] rmem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 128'h0;
  endfunction

  // Lane-wise modulo-2^16 add, upper 32 bits kept
  function automatic logic [127:0] acc_model(input logic [127:0] b, input logic [95:0] p);
    logic [127:0] r;
    r = b;
    for (int k = 0; k < 6; k++) r[k*16 +: 16] = 16'(b[k*16 +: 16] + p[k*16 +: 16]);
    return r;
  endfunction

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    int           cyc;
  } sb_t;
  sb_t sb [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: push expected writes on accept, pop and compare on write
  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst_n) begin
        n_cmp++;
        if ($countones(bus.req_ready) > 1) begin
          n_fail++;
          $display("FAIL ready_onehot: got %b expected at most one bit", bus.req_ready);
        end
        if (bus.bram_we_b) begin
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_write: addr %h data %h", bus.bram_addr_b, bus.bram_wdata_b);
          end else begin
            sb_t e;
            e = sb.pop_front();
            n_cmp++;
            if (bus.bram_addr_b !== e.addr || bus.bram_wdata_b !== e.data || cyc != e.cyc) begin
              n_fail++;
              $display("FAIL sb_write: got addr %h data %h cyc %0d expected addr %h data %h cyc %0d",
                       bus.bram_addr_b, bus.bram_wdata_b, cyc, e.addr, e.data, e.cyc);
            end
          end
        end
        if (bus.acc_done || bus.bram_we_b) begin
          n_cmp++;
          if (bus.acc_done !== bus.bram_we_b) begin
            n_fail++;
            $display("FAIL acc_done: got %b expected %b", bus.acc_done, bus.bram_we_b);
          end
        end
        for (int i = 0; i < NR; i++) begin
          if (bus.req_valid[i] && bus.req_ready[i]) begin
            sb_t e;
            e.addr = addr_a[i];
            e.data = acc_model(rref(addr_a[i]), psum_a[i]);
            e.cyc  = cyc + 3;
            ref_mem[addr_a[i]] = e.data;
            sb.push_back(e);
          end
        end
      end
    end
  end

  // Present one request from cluster cl alone; returns the accept cycle
  task automatic req1(input int cl, input logic [31:0] a, input logic [95:0] p, output int ac);
    int n;
    n  = 0;
    ac = -1;
    @(negedge clk);
    vld = '0;
    vld[cl] = 1'b1;
    addr_a[cl] = a;
    psum_a[cl] = p;
    #3;
    forever begin
      if (bus.req_ready[cl]) begin
        ac = cyc;
        break;
      end
      if (n == 20) begin
        n_cmp++; n_fail++;
        $display("FAIL req_timeout: cluster %0d addr %h never accepted", cl, a);
        break;
      end
      n++;
      @(negedge clk);
      #3;
    end
  endtask

  task automatic release_all();
    @(negedge clk);
    vld = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(bus.idle && sb.size() == 0) && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain_idle", {127'h0, bus.idle}, 128'h1);
    chk("drain_sb_empty", 128'(sb.size()), 128'h0);
  endtask

  typedef struct {
    int           cl;
    logic [31:0]  addr;
    logic [95:0]  psum;
    logic [127:0] init;
    logic [127:0] exp;
  } vec_t;
  vec_t vt [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac, c0, c1, c2, gap1, gap2;
    logic [3:0]   eg;
    logic [127:0] w;
    int           gi;

`ifdef PSUM_HAZARD_FWD_EN
    gap1 = 1; gap2 = 2;
`else
    gap1 = 3; gap2 = 3;
`endif

    vt[0].cl = 0; vt[0].addr = 32'h0000_0010;
    vt[0].psum = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    vt[0].init = {32'hDEADBEEF, {6{16'h0005}}};
    vt[0].exp  = {32'hDEADBEEF, 16'd11, 16'd10, 16'd9, 16'd8, 16'd7, 16'd6};
    vt[1].cl = 1; vt[1].addr = 32'h0000_0030;
    vt[1].psum = {80'h0, 16'h0002};
    vt[1].init = {32'h0, 64'h0, 16'h1234, 16'hFFFF};
    vt[1].exp  = {32'h0, 64'h0, 16'h1234, 16'h0001};
    vt[2].cl = 2; vt[2].addr = 32'h0000_0044;
    vt[2].psum = {6{16'hFFFF}};
    vt[2].init = {32'hA5A5A5A5, {6{16'hFFFF}}};
    vt[2].exp  = {32'hA5A5A5A5, {6{16'hFFFE}}};
    vt[3].cl = 3; vt[3].addr = 32'hFFFF_FFF0;
    vt[3].psum = {16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    vt[3].init = {32'h12345678, 96'h0};
    vt[3].exp  = {32'h12345678, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};

    rst_n = 1'b0;
    vld   = '0;
    for (int i = 0; i < NR; i++) begin
      addr_a[i] = '0;
      psum_a[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    chk("rst_ready", 128'(bus.req_ready), 128'h0);
    chk("rst_en_a", 128'(bus.bram_en_a), 128'h0);
    chk("rst_addr_a", 128'(bus.bram_addr_a), 128'h0);
    chk("rst_we_b", 128'(bus.bram_we_b), 128'h0);
    chk("rst_addr_b", 128'(bus.bram_addr_b), 128'h0);
    chk("rst_wdata_b", bus.bram_wdata_b, 128'h0);
    chk("rst_acc_done", 128'(bus.acc_done), 128'h0);
    chk("rst_idle", 128'(bus.idle), 128'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with all clusters valid and distinct addresses
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      addr_a[i] = 32'h0000_1000 + 32'(i) * 32'h100;
      psum_a[i] = {$urandom, $urandom, $urandom};
    end
    vld = '1;
    for (int k = 0; k < 8; k++) begin
      #3;
      eg = 4'(1) << (k % 4);
      chk("rr_grant", 128'(bus.req_ready), 128'(eg));
      gi = -1;
      for (int j = 0; j < NR; j++) if (bus.req_ready[j]) gi = j;
      @(negedge clk);
      if (gi >= 0) begin
        addr_a[gi] = 32'h0000_1000 + 32'(gi) * 32'h100 + 32'(k + 1) * 32'h4;
        psum_a[gi] = {$urandom, $urandom, $urandom};
      end
    end
    vld = '0;
    drain();

    // Table vectors: isolated requests, write checked 2 cycles after RD
    for (int v = 0; v < 4; v++) begin
      mem[vt[v].addr]     = vt[v].init;
      ref_mem[vt[v].addr] = vt[v].init;
      req1(vt[v].cl, vt[v].addr, vt[v].psum, ac);
      release_all();
      repeat (2) @(negedge clk);
      #3;
      chk("vec_we_b", 128'(bus.bram_we_b), 128'h1);
      chk("vec_addr_b", 128'(bus.bram_addr_b), 128'(vt[v].addr));
      chk("vec_wdata_b", bus.bram_wdata_b, vt[v].exp);
      drain();
    end

    // Back-to-back same address
    mem[32'h20] = '0;
    ref_mem[32'h20] = '0;
    req1(0, 32'h20, 96'h1, c0);
    req1(0, 32'h20, 96'h1, c1);
    req1(0, 32'h20, 96'h1, c2);
    release_all();
    chk("b2b_gap1", 128'(c1 - c0), 128'(gap1));
    chk("b2b_gap2", 128'(c2 - c1), 128'(gap1));
    drain();
    w = rmem(32'h20);
    chk("b2b_final", w, 128'h3);

    // Same address at accepts 0 and 2 with a distinct one between
    mem[32'h40] = {32'h0, {6{16'h0100}}};
    ref_mem[32'h40] = {32'h0, {6{16'h0100}}};
    req1(0, 32'h40, {6{16'h0001}}, c0);
    req1(1, 32'h44, {6{16'h0007}}, c1);
    req1(0, 32'h40, {6{16'h0010}}, c2);
    release_all();
    chk("cmt_gap", 128'(c2 - c0), 128'(gap2));
    drain();
    w = rmem(32'h40);
    chk("cmt_final", w, {32'h0, {6{16'h0111}}});

    // Reset with RD and WAIT occupied
    req1(1, 32'h80, {6{16'h0003}}, c0);
    req1(2, 32'h84, {6{16'h0004}}, c1);
    @(negedge clk);
    vld = '0;
    chk("mid_en_a", 128'(bus.bram_en_a), 128'h1);
    chk("mid_idle", 128'(bus.idle), 128'h0);
    #1;
    rst_n = 1'b0;
    sb.delete();
    ref_mem.delete(32'h80);
    ref_mem.delete(32'h84);
    #2;
    chk("rstmid_idle", 128'(bus.idle), 128'h1);
    chk("rstmid_en_a", 128'(bus.bram_en_a), 128'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #3;
      chk("rstmid_we_b", 128'(bus.bram_we_b), 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) addr_a[i] = 32'h0000_0200 + 32'(i) * 32'h4;
    vld = '1;
    #3;
    chk("rstmid_first_grant", 128'(bus.req_ready), 128'h1);
    release_all();
    drain();
    w = rmem(32'h80);
    chk("rstmid_no_write_80", w, 128'h0);
    w = rmem(32'h84);
    chk("rstmid_no_write_84", w, 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
